// File: rtl/spi_frame_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_pkg
//   Shared constants and elaboration-time helpers for the SPI frame memory.
//
//   Optional feature macro: SPI_FRAME_MEMORY_CHECKSUM_EN
//     When defined, one XOR checksum byte is appended after the channel bytes
//     of every frame (CSUM_BYTES = 1); otherwise CSUM_BYTES = 0.
//
//   Contents:
//     BYTE_W         width of one serialised byte
//     CSUM_BYTES     number of trailing checksum bytes per frame (0 or 1)
//     clog2()        ceiling log2, 0 for values <= 1
//     addr_width()   address width for a frame of a given size, minimum 1
//     bytes_per_ch() bytes needed to carry one channel of a given width
//     params_legal() legality of the NUM_CH / CH_WIDTH parameter pair
// -----------------------------------------------------------------------------
package spi_frame_pkg;

    localparam int BYTE_W = 8;

`ifdef SPI_FRAME_MEMORY_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A single-byte frame still needs a one-bit address port.
    function automatic int addr_width(input int total);
        int w;
        w = clog2(total);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int bytes_per_ch(input int width);
        return width / BYTE_W;
    endfunction

    function automatic bit params_legal(input int num_ch, input int ch_width);
        return (num_ch >= 1) && (ch_width >= BYTE_W) && ((ch_width % BYTE_W) == 0);
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// -----------------------------------------------------------------------------
// rise_edge_detect
//   One-cycle rising-edge detector for a level that is already synchronous to
//   clk. The delay register follows the input every cycle, so a level held
//   high produces exactly one pulse.
//
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous active-low reset (clears the delay register)
//     in     in   level to watch
//     pulse  out  high in the cycle where in is 1 and was 0 on the last edge
// -----------------------------------------------------------------------------
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_d <= 1'b0;
        end else begin
            in_d <= in;
        end
    end

    assign pulse = in & ~in_d;

endmodule

// File: rtl/spi_frame_memory.sv
// -----------------------------------------------------------------------------
// spi_frame_memory
//   Snapshots NUM_CH channel values on a rising edge of frame_start and
//   presents them one byte at a time to the SPI slave transmit path; every
//   rising edge of incr advances to the next byte. The address saturates at
//   the last byte and a further incr edge sets the sticky overrun flag, which
//   only the next frame start clears.
//
//   Optional feature macro: SPI_FRAME_MEMORY_CHECKSUM_EN
//     Appends one byte holding the XOR of all channel bytes of the snapshot;
//     last_byte and overrun then refer to that checksum byte.
//
//   Parameters:
//     NUM_CH     channels per frame (1..16)
//     CH_WIDTH   bits per channel, multiple of 8 (8..32)
//     MSB_FIRST  1: most significant byte of each channel first, 0: LSB first
//
//   Ports:
//     clk          in   system clock
//     rst          in   asynchronous active-low reset
//     frame_start  in   level; rising edge snapshots ch_data, restarts at 0
//     incr         in   level; rising edge advances the byte address
//     ch_data      in   flat channel bus, channel 0 in the LSBs
//     out_byte     out  byte at the current address
//     byte_idx     out  current byte address
//     last_byte    out  high while byte_idx addresses the final byte
//     overrun      out  sticky, incr edge seen while on the final byte
// -----------------------------------------------------------------------------
module spi_frame_memory
    import spi_frame_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CH_WIDTH  = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       incr,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    output logic [BYTE_W-1:0]          out_byte,
    output logic [addr_width(NUM_CH*bytes_per_ch(CH_WIDTH)+CSUM_BYTES)-1:0] byte_idx,
    output logic                       last_byte,
    output logic                       overrun
);

    localparam int BPC        = bytes_per_ch(CH_WIDTH);
    localparam int DATA_BYTES = NUM_CH * BPC;
    localparam int TOTAL      = DATA_BYTES + CSUM_BYTES;
    localparam int AW         = addr_width(TOTAL);
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

    if (!params_legal(NUM_CH, CH_WIDTH)) begin : g_bad_params
        $error("spi_frame_memory: CH_WIDTH must be a multiple of 8 and NUM_CH >= 1");
    end

    logic                       fs_edge;
    logic                       inc_edge;
    logic [NUM_CH*CH_WIDTH-1:0] shadow;
    logic [AW-1:0]              addr;
    logic [BYTE_W-1:0]          byte_arr [TOTAL];

    rise_edge_detect u_fs_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (frame_start),
        .pulse (fs_edge)
    );

    rise_edge_detect u_inc_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (incr),
        .pulse (inc_edge)
    );

    // Frame start has priority: an incr edge in the same cycle is dropped so
    // a new frame always begins presenting byte 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow  <= '0;
            addr    <= '0;
            overrun <= 1'b0;
        end else if (fs_edge) begin
            shadow  <= ch_data;
            addr    <= '0;
            overrun <= 1'b0;
        end else if (inc_edge) begin
            if (addr < LAST_ADDR) begin
                addr <= addr + AW'(1);
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    // Static byte map of the snapshot: address a carries byte k of channel
    // a/BPC, with k counted from the top when MSB_FIRST is set.
    for (genvar a = 0; a < DATA_BYTES; a++) begin : g_byte_map
        localparam int CH = a / BPC;
        localparam int K  = a % BPC;
        localparam int SH = (MSB_FIRST != 0) ? (BPC - 1 - K) : K;
        assign byte_arr[a] = shadow[CH*CH_WIDTH + SH*BYTE_W +: BYTE_W];
    end

`ifdef SPI_FRAME_MEMORY_CHECKSUM_EN
    // Byte order does not change the XOR, so the whole shadow is folded.
    logic [BYTE_W-1:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < NUM_CH*BPC; i++) begin
            csum = csum ^ shadow[i*BYTE_W +: BYTE_W];
        end
    end

    assign byte_arr[DATA_BYTES] = csum;
`endif

    always_comb begin
        out_byte = '0;
        for (int i = 0; i < TOTAL; i++) begin
            if (addr == AW'(i)) begin
                out_byte = byte_arr[i];
            end
        end
    end

    assign byte_idx  = addr;
    assign last_byte = (addr == LAST_ADDR);

endmodule

// File: tb/tb_spi_frame_memory.sv
module tb_spi_frame_memory;

    localparam int NUM_CH   = 4;
    localparam int CH_WIDTH = 16;
    localparam int BPC      = CH_WIDTH / 8;
    localparam int DBYTES   = NUM_CH * BPC;
`ifdef SPI_FRAME_MEMORY_CHECKSUM_EN
    localparam int TOTAL    = DBYTES + 1;
`else
    localparam int TOTAL    = DBYTES;
`endif
    localparam int AW = ($clog2(TOTAL) < 1) ? 1 : $clog2(TOTAL);

    logic                       clk = 1'b0;
    logic                       clk_en = 1'b1;
    logic                       rst = 1'b0;
    logic                       frame_start = 1'b0;
    logic                       incr = 1'b0;
    logic [NUM_CH*CH_WIDTH-1:0] ch_data = '0;

    logic [7:0]    out_msb, out_lsb;
    logic [AW-1:0] idx_msb, idx_lsb;
    logic          last_msb, last_lsb, ovr_msb, ovr_lsb;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    spi_frame_memory #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .frame_start(frame_start), .incr(incr), .ch_data(ch_data),
        .out_byte(out_msb), .byte_idx(idx_msb), .last_byte(last_msb), .overrun(ovr_msb)
    );

    spi_frame_memory #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .frame_start(frame_start), .incr(incr), .ch_data(ch_data),
        .out_byte(out_lsb), .byte_idx(idx_lsb), .last_byte(last_lsb), .overrun(ovr_lsb)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_ch [NUM_CH] = '{default: 32'd0};
    int          m_idx  = 0;
    bit          m_ovr  = 1'b0;
    bit          m_fs_prev  = 1'b0;
    bit          m_inc_prev = 1'b0;

    function automatic logic [7:0] m_data_byte(int a, bit msb);
        int ch, k, sh;
        ch = a / BPC;
        k  = a % BPC;
        sh = msb ? (BPC - 1 - k) : k;
        return 8'((m_ch[ch] >> (8 * sh)) & 32'hFF);
    endfunction

    function automatic logic [7:0] m_byte(int a, bit msb);
        logic [7:0] x;
        if (a < DBYTES) return m_data_byte(a, msb);
        x = 8'h00;
        for (int i = 0; i < DBYTES; i++) x = x ^ m_data_byte(i, 1'b1);
        return x;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) m_ch[c] = 32'd0;
            m_idx = 0;
            m_ovr = 1'b0;
            m_fs_prev = 1'b0;
            m_inc_prev = 1'b0;
        end else begin
            if (frame_start && !m_fs_prev) begin
                for (int c = 0; c < NUM_CH; c++)
                    m_ch[c] = 32'((ch_data >> (c * CH_WIDTH)) & ((64'd1 << CH_WIDTH) - 1));
                m_idx = 0;
                m_ovr = 1'b0;
            end else if (incr && !m_inc_prev) begin
                if (m_idx == TOTAL - 1) m_ovr = 1'b1;
                else m_idx = m_idx + 1;
            end
            m_fs_prev = frame_start;
            m_inc_prev = incr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_idx_msb",  32'(idx_msb),  32'(m_idx));
            check("cyc_idx_lsb",  32'(idx_lsb),  32'(m_idx));
            check("cyc_byte_msb", 32'(out_msb),  32'(m_byte(m_idx, 1'b1)));
            check("cyc_byte_lsb", 32'(out_lsb),  32'(m_byte(m_idx, 1'b0)));
            check("cyc_last_msb", 32'(last_msb), 32'(m_idx == TOTAL - 1));
            check("cyc_last_lsb", 32'(last_lsb), 32'(m_idx == TOTAL - 1));
            check("cyc_ovr_msb",  32'(ovr_msb),  32'(m_ovr));
            check("cyc_ovr_lsb",  32'(ovr_lsb),  32'(m_ovr));
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [63:0] TEST_DATA = {16'hD4C3, 16'hB2A1, 16'h5678, 16'h1234};
    logic [7:0] seq_msb [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hB2, 8'hA1, 8'hD4, 8'hC3};
    logic [7:0] seq_lsb [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
`ifdef SPI_FRAME_MEMORY_CHECKSUM_EN
    localparam logic [7:0] LAST_LIT = 8'h0C;
`else
    localparam logic [7:0] LAST_LIT = 8'hC3;
`endif

    task automatic new_frame();
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_incr();
        incr = 1'b1;
        @(negedge clk);
        incr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(out_msb), 32'h0);
        check("rst_idx",  32'(idx_msb), 32'h0);
        check("rst_last", 32'(last_msb), 32'(TOTAL == 1));
        check("rst_ovr",  32'(ovr_msb), 32'h0);
        rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // basic frame, both byte orders
        ch_data = TEST_DATA;
        new_frame();
        for (int i = 0; i < 8; i++) begin
            check("seq_msb", 32'(out_msb), 32'(seq_msb[i]));
            check("seq_lsb", 32'(out_lsb), 32'(seq_lsb[i]));
            check("seq_last", 32'(last_msb), 32'(i == TOTAL - 1));
            if (i < 7) pulse_incr();
        end
`ifdef SPI_FRAME_MEMORY_CHECKSUM_EN
        pulse_incr();
        check("csum_msb", 32'(out_msb), 32'h0C);
        check("csum_lsb", 32'(out_lsb), 32'h0C);
        check("csum_last", 32'(last_msb), 32'h1);
`endif

        // ch_data changes after snapshot are invisible
        new_frame();
        pulse_incr();
        pulse_incr();
        ch_data = {NUM_CH{16'hFFFF}};
        for (int i = 2; i < 8; i++) begin
            check("snap_hold", 32'(out_msb), 32'(seq_msb[i]));
            if (i < 7) pulse_incr();
        end
        new_frame();
        check("resnap_ff", 32'(out_msb), 32'hFF);

        // overrun at the last byte
        ch_data = TEST_DATA;
        new_frame();
        repeat (TOTAL) pulse_incr();
        check("ovr_idx",  32'(idx_msb), 32'(TOTAL - 1));
        check("ovr_byte", 32'(out_msb), 32'(LAST_LIT));
        check("ovr_flag", 32'(ovr_msb), 32'h1);
        new_frame();
        check("ovr_clr",  32'(ovr_msb), 32'h0);
        check("ovr_idx0", 32'(idx_msb), 32'h0);

        // simultaneous frame start and incr, then incr held high
        repeat (3) pulse_incr();
        check("pre_sim_idx", 32'(idx_msb), 32'h3);
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        incr = 1'b1;
        @(negedge clk);
        check("sim_idx", 32'(idx_msb), 32'h0);
        incr = 1'b0;
        @(negedge clk);
        incr = 1'b1;
        repeat (10) @(negedge clk);
        incr = 1'b0;
        @(negedge clk);
        check("held_idx", 32'(idx_msb), 32'h1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 11) == 0) frame_start = ~frame_start;
            if ($urandom_range(0, 1) == 0) incr = ~incr;
            if ($urandom_range(0, 7) == 0) ch_data = {$urandom, $urandom};
            @(negedge clk);
        end

        // asynchronous reset with the clock stopped
        frame_start = 1'b0;
        incr = 1'b0;
        ch_data = TEST_DATA;
        new_frame();
        repeat (5) pulse_incr();
        check("pre_rst_idx", 32'(idx_msb), 32'h5);
        clk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_byte", 32'(out_msb), 32'h0);
        check("arst_idx",  32'(idx_msb), 32'h0);
        check("arst_ovr",  32'(ovr_msb), 32'h0);
        check("arst_last", 32'(last_msb), 32'(TOTAL == 1));
        #5;
        rst = 1'b1;
        frame_start = 1'b0;
        clk_en = 1'b1;
        repeat (4) @(negedge clk);
        new_frame();
        check("post_rst_byte", 32'(out_msb), 32'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
